// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM peripheral: register word addresses
// and the prescaler width.
package led_pwm_pkg;

  localparam int ADDR_DIRECT    = 0;
  localparam int ADDR_MODE      = 1;
  localparam int ADDR_PRESCALE  = 2;
  localparam int ADDR_COUNT     = 3;
  localparam int ADDR_DUTY_BASE = 4;

  localparam int PRESCALE_W     = 16;

endpackage

// File: rtl/led_pwm_ctrl_timebase.sv
// Shared PWM timebase: a prescaler producing a one-cycle tick every
// prescale+1 cycles, and the free-running PWM counter it advances.
module pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  prescale_wr,
  output logic                  tick,
  output logic                  period_start,
  output logic [PWM_W-1:0]      pwm_cnt
);

  logic [PRESCALE_W-1:0] presc_cnt_reg, presc_cnt_next;
  logic [PWM_W-1:0]      pwm_cnt_reg, pwm_cnt_next;

  always_comb begin
    tick         = (presc_cnt_reg == prescale);
    period_start = tick && (pwm_cnt_reg == '1);
    // A new prescale value restarts the divider; the tick still uses the old phase.
    presc_cnt_next = (prescale_wr || tick) ? '0 : presc_cnt_reg + PRESCALE_W'(1);
    pwm_cnt_next   = tick ? pwm_cnt_reg + PWM_W'(1) : pwm_cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_reg <= '0;
      pwm_cnt_reg   <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
      pwm_cnt_reg   <= pwm_cnt_next;
    end
  end

  assign pwm_cnt = pwm_cnt_reg;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Avalon-MM LED controller: per-channel direct or PWM drive, with duty
// values shadowed to PWM period boundaries so outputs never glitch.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int PWM_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] led_out
);

  logic                          wr_en, rd_en;
  logic                          wr_direct, wr_mode, wr_prescale;
  logic [NUM_CH-1:0]             direct_reg, mode_reg;
  logic [PRESCALE_W-1:0]         prescale_reg;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_val;
  logic [NUM_CH-1:0]             led_next, led_out_reg;
  logic [31:0]                   rd_data, readdata_reg;
  logic                          unused_tick, period_start;
  logic [PWM_W-1:0]              pwm_cnt;
  logic                          unused_wdata;

  assign wr_en        = chipselect && write;
  assign rd_en        = chipselect && read;
  assign wr_direct    = wr_en && (address == ADDR_W'(ADDR_DIRECT));
  assign wr_mode      = wr_en && (address == ADDR_W'(ADDR_MODE));
  assign wr_prescale  = wr_en && (address == ADDR_W'(ADDR_PRESCALE));
  assign unused_wdata = ^writedata;

  pwm_timebase #(
    .PWM_W (PWM_W)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .prescale     (prescale_reg),
    .prescale_wr  (wr_prescale),
    .tick         (unused_tick),
    .period_start (period_start),
    .pwm_cnt      (pwm_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      direct_reg   <= '0;
      mode_reg     <= '0;
      prescale_reg <= '0;
    end else begin
      if (wr_direct)   direct_reg   <= writedata[NUM_CH-1:0];
      if (wr_mode)     mode_reg     <= writedata[NUM_CH-1:0];
      if (wr_prescale) prescale_reg <= writedata[PRESCALE_W-1:0];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             duty_we;
      logic [PWM_W-1:0] duty_reg, duty_sh_reg;

      assign duty_we = wr_en && (address == ADDR_W'(ADDR_DUTY_BASE + gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          duty_reg    <= '0;
          duty_sh_reg <= '0;
        end else begin
          if (duty_we) duty_reg <= writedata[PWM_W-1:0];
          // Direct-mode channels track duty continuously so PWM entry starts clean.
          if (period_start || !mode_reg[gi]) duty_sh_reg <= duty_reg;
        end
      end

      assign duty_val[gi] = duty_reg;
      assign led_next[gi] = mode_reg[gi] ? (pwm_cnt < duty_sh_reg) : direct_reg[gi];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (address == ADDR_W'(ADDR_DIRECT)) begin
      rd_data[NUM_CH-1:0] = direct_reg;
    end else if (address == ADDR_W'(ADDR_MODE)) begin
      rd_data[NUM_CH-1:0] = mode_reg;
    end else if (address == ADDR_W'(ADDR_PRESCALE)) begin
      rd_data[PRESCALE_W-1:0] = prescale_reg;
    end else if (address == ADDR_W'(ADDR_COUNT)) begin
      rd_data[PWM_W-1:0] = pwm_cnt;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == ADDR_W'(ADDR_DUTY_BASE + i)) rd_data[PWM_W-1:0] = duty_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
      led_out_reg  <= '0;
    end else begin
      if (rd_en) readdata_reg <= rd_data;
      led_out_reg <= led_next;
    end
  end

  assign readdata = readdata_reg;
  assign led_out  = led_out_reg;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Randomised scoreboard bench for led_pwm_ctrl: a cycle-indexed reference
// model queues expected LED/read values, a monitor pops and compares them.
module tb_led_pwm_ctrl;

  localparam int NUM_CH = 10;
  localparam int PWM_W  = 8;
  localparam int ADDR_W = 4;
  localparam int NPER   = 1 << PWM_W;
  localparam int CMAX   = NPER - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] led_out;

  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .NUM_CH (NUM_CH),
    .PWM_W  (PWM_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  typedef enum int {K_LED, K_RD, K_HSTART, K_HEND} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mon_cyc  = 0;
  int   hi_acc   = 0;

  // Reference model: register contents plus an arithmetic description of
  // the counter (count = base + elapsed cycles / (prescale+1)).
  logic [NUM_CH-1:0] m_direct, m_mode;
  int m_presc, m_base, m_seg;
  int m_duty[NUM_CH];
  int m_sh[NUM_CH];

  function automatic int cnt_at(int t);
    return (m_base + (t - m_seg) / (m_presc + 1)) % NPER;
  endfunction

  function automatic logic [31:0] reg_value(int a, int t);
    if (a == 0) return 32'(m_direct);
    if (a == 1) return 32'(m_mode);
    if (a == 2) return 32'(m_presc);
    if (a == 3) return 32'(cnt_at(t));
    if (a >= 4 && a < 4 + NUM_CH) return 32'(m_duty[a-4]);
    return 32'd0;
  endfunction

  task automatic push(int t, kind_t k, logic [31:0] v);
    exp_t e;
    e.cyc  = t;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  // Model the cycle whose inputs are currently driven, then clock it.
  task automatic step();
    logic [NUM_CH-1:0] exp_led;
    int c_now, c_nxt, a;
    a = int'(address);
    if (reset) begin
      push(cyc + 1, K_LED, 32'd0);
      push(cyc + 1, K_RD, 32'd0);
      m_direct = '0; m_mode = '0;
      m_presc = 0; m_base = 0; m_seg = cyc + 1;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
    end else begin
      c_now = cnt_at(cyc);
      c_nxt = cnt_at(cyc + 1);
      for (int i = 0; i < NUM_CH; i++)
        exp_led[i] = m_mode[i] ? (c_now < m_sh[i]) : m_direct[i];
      push(cyc + 1, K_LED, 32'(exp_led));
      if (chipselect && read) push(cyc + 1, K_RD, reg_value(a, cyc));
      for (int i = 0; i < NUM_CH; i++)
        if ((c_now == CMAX && c_nxt == 0) || !m_mode[i]) m_sh[i] = m_duty[i];
      if (chipselect && write) begin
        if (a == 0) m_direct = writedata[NUM_CH-1:0];
        else if (a == 1) m_mode = writedata[NUM_CH-1:0];
        else if (a == 2) begin
          m_base  = c_nxt;
          m_seg   = cyc + 1;
          m_presc = int'(writedata[15:0]);
        end else if (a >= 4 && a < 4 + NUM_CH) m_duty[a-4] = int'(writedata[PWM_W-1:0]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus_write(int a, logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = ADDR_W'(a); writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(int a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    address = ADDR_W'(a);
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_rw(int a, logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = ADDR_W'(a); writedata = d;
    step();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // Counts led_out[0] high cycles over len cycles and expects expv.
  task automatic hi_window(int len, int expv);
    push(cyc + 1, K_HSTART, 32'd0);
    idle(len);
    push(cyc + 1, K_HEND, 32'(expv));
  endtask

  // Monitor: pops every entry due in the current cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mon_cyc++;
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= mon_cyc) begin
        e = sb_q.pop_front();
        if (e.kind == K_HSTART) begin
          hi_acc = 0;
        end else begin
          n_checks++;
          if (e.cyc < mon_cyc) begin
            n_fail++;
            $display("FAIL stale_entry cyc=%0d now=%0d", e.cyc, mon_cyc);
          end else if (e.kind == K_LED) begin
            if (led_out !== e.val[NUM_CH-1:0]) begin
              n_fail++;
              $display("FAIL led_out cyc=%0d got=%h exp=%h", mon_cyc, led_out, e.val[NUM_CH-1:0]);
            end
          end else if (e.kind == K_RD) begin
            if (readdata !== e.val) begin
              n_fail++;
              $display("FAIL readdata cyc=%0d got=%h exp=%h", mon_cyc, readdata, e.val);
            end else begin
              $display("read ok cyc=%0d data=%h", mon_cyc, readdata);
            end
          end else begin
            if (hi_acc != int'(e.val)) begin
              n_fail++;
              $display("FAIL high_count cyc=%0d got=%0d exp=%0d", mon_cyc, hi_acc, e.val);
            end else begin
              $display("window ok cyc=%0d high=%0d", mon_cyc, hi_acc);
            end
          end
        end
      end
      hi_acc += int'(led_out[0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    idle(2);
    reset = 1'b0;
    bus_read(3);
    bus_read(0);
    idle(2);

    // Direct path
    bus_write(0, 32'h0000_02A5);
    idle(1);
    bus_read(0);
    idle(2);

    // Random register traffic with PWM and direct channels mixed
    for (int k = 0; k < 300; k++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      read       = $urandom_range(0, 1) == 1;
      write      = $urandom_range(0, 1) == 1;
      address    = ADDR_W'($urandom_range(0, 15));
      writedata  = $urandom;
      if (address == ADDR_W'(2)) writedata = writedata & 32'hFFFF_0003;
      step();
    end
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    for (int a = 0; a < 16; a++) bus_read(a);

    // Duty sweep, PRESCALE=0
    bus_write(1, 32'h0);
    bus_write(4, 32'd64);
    bus_write(1, 32'h1);
    bus_write(2, 32'h0);
    idle(300);
    hi_window(256, 64);

    // Shadowing: mid-period change from 64 to 192
    for (int k = 0; k < NPER && cnt_at(cyc) != 0; k++) idle(1);
    p = cyc;
    push(cyc + 1, K_HSTART, 32'd0);
    idle(100);
    bus_write(4, 32'd192);
    idle(p + 256 - cyc);
    push(cyc + 1, K_HEND, 32'd64);
    hi_window(256, 192);

    bus_write(4, 32'd0);
    idle(520);
    hi_window(256, 0);
    bus_write(4, 32'd255);
    idle(520);
    hi_window(256, 255);

    // Prescale 3: period of 1024 cycles
    bus_write(4, 32'd64);
    bus_write(2, 32'd3);
    idle(2100);
    hi_window(1024, 256);
    for (int k = 0; k < 6; k++) begin bus_read(3); idle(1); end

    // Corner cases
    bus_write(3, 32'hFFFF_FFFF);
    bus_write(14, 32'hDEAD_BEEF);
    bus_write(15, 32'h1234_5678);
    bus_read(14);
    bus_read(15);
    bus_read(3);
    bus_write(5, 32'h11);
    bus_rw(5, 32'h22);
    bus_read(5);

    // Reset mid-period
    bus_write(2, 32'd0);
    idle(77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_read(3);
    bus_read(3);
    idle(3);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
